calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Keypad-driven sequencer for the 16-bit calculator datapath: 2:1 mux (keypad operand / ALU result), 32x16 register bank, ALU, 7-segment display.
- Assembles operands from hex key presses and writes them to the register bank.
- Then runs the selected ALU operation, writes the result back and pulses the display update.
- Owns every write-enable, address, mux-select and ALU-control signal. The keypad scanner/debouncer drives key_detect_i and teclado_i.

Parameters:
- ADDR_A, 5'd1, register-bank address for operand A.
- ADDR_B, 5'd2, register-bank address for operand B.
- ADDR_RES, 5'd3, register-bank address for the result.
- ALU_LAT, 2, cycles to wait after driving ALU operands/op before writing the result (1..7).
- OP_ADD / OP_SUB / OP_AND / OP_OR, 4'h0 / 4'h1 / 4'h2 / 4'h3, ALU control codes for keys A / B / C / D.

Ports:
- clk  in  1  system clock (clk_10MHz domain).
- reset_ni  in  1  asynchronous, active-low reset.
- key_detect_i  in  1  debounced key-held level, synchronous to clk.
- teclado_i  in  4  key code, valid while key_detect_i=1.
- operand_o  out  16  assembled operand, to mux keypad input.
- mux_sel_o  out  1  0 = operand_o, 1 = ALU result.
- we_o  out  1  register-bank write enable.
- waddr_o  out  5  write address.
- raddr1_o  out  5  read port 1 address (ALU A).
- raddr2_o  out  5  read port 2 address (ALU B / display).
- alu_op_o  out  4  ALU control.
- display_en_o  out  1  one-cycle display-register load pulse.
- busy_o  out  1  high in WR_A, WR_B, EXEC, WR_RES, SHOW.
- error_o  out  3  latched error code.

Behaviour:
- Reset (async assert, sync release):
  - State ENTER_A; all outputs 0 except raddr1_o=ADDR_A and raddr2_o=ADDR_B.
  - Internal digit counter 0, operand register 0.
- Key event: rising edge of key_detect_i, detected with one registered copy. Exactly one event per press; holding the key produces no repeats.
- Key map:
  - 0x0-0x9: digit.
  - 0xA-0xD: operator.
  - 0xE: equals.
  - 0xF: clear.
- Digit event in ENTER_A or ENTER_B:
  - If count < 4: operand <= {operand[11:0], key}; count+1.
  - If count = 4: digit ignored, error=3'b011.
- Operator event in ENTER_A:
  - count = 0: error=3'b001, stay in ENTER_A.
  - Otherwise: latch alu_op, go to WR_A.
- WR_A (1 cycle): we_o=1, waddr_o=ADDR_A, mux_sel_o=0. Then clear operand and count, go to ENTER_B.
- Equals event in ENTER_B:
  - count = 0: error=3'b010, stay in ENTER_B.
  - Otherwise: go to WR_B.
- WR_B (1 cycle): we_o=1, waddr_o=ADDR_B, mux_sel_o=0. Then go to EXEC.
- EXEC: raddr1_o=ADDR_A, raddr2_o=ADDR_B, alu_op_o driven. Wait ALU_LAT cycles (down-counter), then go to WR_RES.
- WR_RES (1 cycle): we_o=1, mux_sel_o=1, waddr_o=ADDR_RES, inputs held. Then go to SHOW.
- SHOW (1 cycle): raddr2_o=ADDR_RES, display_en_o=1. Then go to DONE.
- DONE: raddr2_o held at ADDR_RES so the result stays displayed.
  - Digit: operand cleared and digit loaded as first digit (count=1), go to ENTER_A.
  - Operator or equals: ignored.
- Fixed write timing: we_o high exactly one cycle per write; equals to display_en_o = 3+ALU_LAT cycles.
- Clear (0xF): in any non-busy state, operand=0, count=0, error=0, go to ENTER_A, next cycle.
- Any key event while busy_o=1 (clear included): ignored, error=3'b100.
- Error codes:
  - error_o holds until the next accepted key, which sets it to 0 unless that key itself errors.
  - Simultaneous sources cannot occur (one event per cycle).
- Operator key in ENTER_B: ignored, no error. Equals in ENTER_A: ignored, no error.
- Arithmetic: operand is unsigned 16-bit hex. ALU carry/zero are not consumed by this block.
- Reset asserted mid-sequence: immediate return to reset values. No partial write completes after the reset edge.

Test Plan:
1. Keys 1,2,A,3,E -> WR_A writes 16'h0012 @ADDR_A, WR_B writes 16'h0003 @ADDR_B, alu_op_o=OP_ADD, WR_RES with mux_sel_o=1, display_en_o pulse exactly 3+ALU_LAT cycles after the equals edge, raddr2_o=ADDR_RES.
2. Keys 1,2,3,4,5 -> operand_o=16'h1234, error_o=3'b011; then key C -> error_o=0, WR_A writes 16'h1234.
3. Key A from reset -> error_o=3'b001, no we_o pulse. Then 7,B,E -> error_o=3'b010, still in ENTER_B.
4. Key press with key_detect_i held high 50 cycles during EXEC -> single event, error_o=3'b100, sequence completes unchanged.
5. reset_ni low during EXEC -> outputs zero asynchronously, no we_o in following cycles, state ENTER_A.
6. From DONE press 9 -> ENTER_A, operand_o=16'h0009. Press F -> operand_o=0, error_o=0.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Keypad/datapath bundle for calc_sequencer: key inputs in, register-bank,
// mux, ALU and display controls out.
interface calc_sequencer_if;
  logic        key_detect_i;
  logic [3:0]  teclado_i;
  logic [15:0] operand_o;
  logic        mux_sel_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [4:0]  raddr1_o;
  logic [4:0]  raddr2_o;
  logic [3:0]  alu_op_o;
  logic        display_en_o;
  logic        busy_o;
  logic [2:0]  error_o;

  modport master (
    input  key_detect_i,
    input  teclado_i,
    output operand_o,
    output mux_sel_o,
    output we_o,
    output waddr_o,
    output raddr1_o,
    output raddr2_o,
    output alu_op_o,
    output display_en_o,
    output busy_o,
    output error_o
  );

  modport slave (
    output key_detect_i,
    output teclado_i,
    input  operand_o,
    input  mux_sel_o,
    input  we_o,
    input  waddr_o,
    input  raddr1_o,
    input  raddr2_o,
    input  alu_op_o,
    input  display_en_o,
    input  busy_o,
    input  error_o
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the 16-bit calculator: assembles hex operands,
// writes them to the register bank, runs the ALU and pulses the display load.
module calc_sequencer #(
  parameter logic [4:0] ADDR_A   = 5'd1,
  parameter logic [4:0] ADDR_B   = 5'd2,
  parameter logic [4:0] ADDR_RES = 5'd3,
  parameter int         ALU_LAT  = 2,
  parameter logic [3:0] OP_ADD   = 4'h0,
  parameter logic [3:0] OP_SUB   = 4'h1,
  parameter logic [3:0] OP_AND   = 4'h2,
  parameter logic [3:0] OP_OR    = 4'h3
) (
  input  logic clk,
  input  logic reset_ni,
  calc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ENTER_A,
    WR_A,
    ENTER_B,
    WR_B,
    EXEC,
    WR_RES,
    SHOW,
    DONE
  } state_t;

  state_t      state;
  logic        key_q;
  logic        evt_q;
  logic [3:0]  key_code;
  logic [15:0] operand;
  logic [2:0]  count;
  logic [2:0]  wait_cnt;
  logic        we;
  logic        mux_sel;
  logic        display_en;
  logic        busy;
  logic [4:0]  waddr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [3:0]  alu_op;
  logic [2:0]  error;
  logic        is_digit;
  logic        is_op;
  logic        is_eq;
  logic        is_clr;
  logic        digit_room;
  logic [3:0]  op_code;

  // The key event and its code are registered together, so the FSM acts one
  // cycle after the edge is sampled; this fixes equals-to-display at 3+ALU_LAT.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      key_q    <= 1'b0;
      evt_q    <= 1'b0;
      key_code <= 4'h0;
    end else begin
      key_q    <= bus.key_detect_i;
      evt_q    <= bus.key_detect_i & ~key_q;
      key_code <= bus.teclado_i;
    end
  end

  assign is_digit   = (key_code <= 4'd9);
  assign is_op      = (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_eq      = (key_code == 4'hE);
  assign is_clr     = (key_code == 4'hF);
  assign digit_room = (count < 3'd4);

  always_comb begin
    op_code = OP_ADD;
    case (key_code)
      4'hB:    op_code = OP_SUB;
      4'hC:    op_code = OP_AND;
      4'hD:    op_code = OP_OR;
      default: op_code = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= ENTER_A;
      operand    <= 16'h0000;
      count      <= 3'd0;
      wait_cnt   <= 3'd0;
      we         <= 1'b0;
      mux_sel    <= 1'b0;
      display_en <= 1'b0;
      busy       <= 1'b0;
      waddr      <= 5'd0;
      raddr1     <= ADDR_A;
      raddr2     <= ADDR_B;
      alu_op     <= 4'h0;
      error      <= 3'b000;
    end else begin
      we         <= 1'b0;
      display_en <= 1'b0;
      case (state)
        ENTER_A: begin
          if (evt_q) begin
            if (is_clr) begin
              operand <= 16'h0000;
              count   <= 3'd0;
              error   <= 3'b000;
            end else if (is_digit) begin
              if (digit_room) begin
                operand <= {operand[11:0], key_code};
                count   <= count + 3'd1;
                error   <= 3'b000;
              end else begin
                error <= 3'b011;
              end
            end else if (is_op) begin
              if (count == 3'd0) begin
                error <= 3'b001;
              end else begin
                alu_op  <= op_code;
                error   <= 3'b000;
                we      <= 1'b1;
                waddr   <= ADDR_A;
                mux_sel <= 1'b0;
                busy    <= 1'b1;
                state   <= WR_A;
              end
            end
          end
        end

        WR_A: begin
          operand <= 16'h0000;
          count   <= 3'd0;
          busy    <= 1'b0;
          state   <= ENTER_B;
          if (evt_q) error <= 3'b100;
        end

        ENTER_B: begin
          if (evt_q) begin
            if (is_clr) begin
              operand <= 16'h0000;
              count   <= 3'd0;
              error   <= 3'b000;
              state   <= ENTER_A;
            end else if (is_digit) begin
              if (digit_room) begin
                operand <= {operand[11:0], key_code};
                count   <= count + 3'd1;
                error   <= 3'b000;
              end else begin
                error <= 3'b011;
              end
            end else if (is_eq) begin
              if (count == 3'd0) begin
                error <= 3'b010;
              end else begin
                error   <= 3'b000;
                we      <= 1'b1;
                waddr   <= ADDR_B;
                mux_sel <= 1'b0;
                busy    <= 1'b1;
                state   <= WR_B;
              end
            end
          end
        end

        WR_B: begin
          raddr1   <= ADDR_A;
          raddr2   <= ADDR_B;
          wait_cnt <= 3'(ALU_LAT);
          state    <= EXEC;
          if (evt_q) error <= 3'b100;
        end

        // wait_cnt is loaded with ALU_LAT on entry, so EXEC lasts ALU_LAT cycles.
        EXEC: begin
          if (wait_cnt <= 3'd1) begin
            we      <= 1'b1;
            mux_sel <= 1'b1;
            waddr   <= ADDR_RES;
            state   <= WR_RES;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
          if (evt_q) error <= 3'b100;
        end

        WR_RES: begin
          mux_sel    <= 1'b0;
          display_en <= 1'b1;
          raddr2     <= ADDR_RES;
          state      <= SHOW;
          if (evt_q) error <= 3'b100;
        end

        SHOW: begin
          busy  <= 1'b0;
          state <= DONE;
          if (evt_q) error <= 3'b100;
        end

        DONE: begin
          if (evt_q) begin
            if (is_clr) begin
              operand <= 16'h0000;
              count   <= 3'd0;
              error   <= 3'b000;
              state   <= ENTER_A;
            end else if (is_digit) begin
              operand <= {12'h000, key_code};
              count   <= 3'd1;
              error   <= 3'b000;
              state   <= ENTER_A;
            end
          end
        end

        default: state <= ENTER_A;
      endcase
    end
  end

  assign bus.operand_o    = operand;
  assign bus.mux_sel_o    = mux_sel;
  assign bus.we_o         = we;
  assign bus.waddr_o      = waddr;
  assign bus.raddr1_o     = raddr1;
  assign bus.raddr2_o     = raddr2;
  assign bus.alu_op_o     = alu_op;
  assign bus.display_en_o = display_en;
  assign bus.busy_o       = busy;
  assign bus.error_o      = error;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key sequences followed by
// random key presses, compared against a key-level calculator model.
module tb_calc_sequencer;

  localparam int         ALU_LAT  = 2;
  localparam int         GAP      = 12;
  localparam logic [4:0] ADDR_A   = 5'd1;
  localparam logic [4:0] ADDR_B   = 5'd2;
  localparam logic [4:0] ADDR_RES = 5'd3;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;

  always #5 clk = ~clk;

  calc_sequencer_if bus();

  calc_sequencer #(.ALU_LAT(ALU_LAT)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic        mux;
    logic [15:0] data;
    logic [3:0]  op;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } wr_t;

  typedef enum {M_A, M_B, M_DONE} mphase_t;

  wr_t     wrLog[$];
  wr_t     expWr[$];
  wr_t     monW;
  wr_t     newW;
  int      cycle = 0;
  int      dispCount = 0;
  int      dispCycle = 0;
  int      expDispCount = 0;
  int      expDispCycle = 0;
  int      vectorCount = 0;
  int      missCount = 0;

  mphase_t     mPhase;
  logic [15:0] mOperand;
  int          mDigits;
  logic [2:0]  mError;
  logic [3:0]  mOp;

  // Records every register-bank write and display pulse, sampled after the edge.
  always begin
    @(posedge clk);
    cycle = cycle + 1;
    #1;
    if (bus.we_o === 1'b1) begin
      monW.addr = bus.waddr_o;
      monW.mux  = bus.mux_sel_o;
      monW.data = bus.operand_o;
      monW.op   = bus.alu_op_o;
      monW.ra1  = bus.raddr1_o;
      monW.ra2  = bus.raddr2_o;
      wrLog.push_back(monW);
    end
    if (bus.display_en_o === 1'b1) begin
      dispCount = dispCount + 1;
      dispCycle = cycle;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPhase   = M_A;
    mOperand = 16'h0000;
    mDigits  = 0;
    mError   = 3'b000;
    mOp      = 4'h0;
  endtask

  task automatic pushWrite(input logic [4:0] addr, input logic mux, input logic [15:0] data, input logic [3:0] op);
    newW.addr = addr;
    newW.mux  = mux;
    newW.data = data;
    newW.op   = op;
    newW.ra1  = ADDR_A;
    newW.ra2  = ADDR_B;
    expWr.push_back(newW);
  endtask

  // Calculator behaviour at the level of whole key presses.
  task automatic modelKey(input logic [3:0] k, input int pressCycle);
    if (k == 4'hF) begin
      mOperand = 16'h0000;
      mDigits  = 0;
      mError   = 3'b000;
      mPhase   = M_A;
    end else if (k <= 4'd9) begin
      if (mPhase == M_DONE) begin
        mOperand = {12'h000, k};
        mDigits  = 1;
        mError   = 3'b000;
        mPhase   = M_A;
      end else if (mDigits < 4) begin
        mOperand = 16'(mOperand * 16 + k);
        mDigits++;
        mError = 3'b000;
      end else begin
        mError = 3'b011;
      end
    end else if (k == 4'hE) begin
      if (mPhase == M_B) begin
        if (mDigits == 0) begin
          mError = 3'b010;
        end else begin
          mError = 3'b000;
          pushWrite(ADDR_B, 1'b0, mOperand, 4'h0);
          pushWrite(ADDR_RES, 1'b1, 16'h0000, mOp);
          expDispCount = expDispCount + 1;
          expDispCycle = pressCycle + 3 + ALU_LAT;
          mPhase = M_DONE;
        end
      end
    end else begin
      if (mPhase == M_A) begin
        if (mDigits == 0) begin
          mError = 3'b001;
        end else begin
          mError = 3'b000;
          case (k)
            4'hA:    mOp = 4'h0;
            4'hB:    mOp = 4'h1;
            4'hC:    mOp = 4'h2;
            default: mOp = 4'h3;
          endcase
          pushWrite(ADDR_A, 1'b0, mOperand, 4'h0);
          mOperand = 16'h0000;
          mDigits  = 0;
          mPhase   = M_B;
        end
      end
    end
  endtask

  task automatic clearLogs();
    wrLog.delete();
    expWr.delete();
    dispCount    = 0;
    expDispCount = 0;
  endtask

  task automatic checkSettled();
    checkOutput("operand", 32'(bus.operand_o), 32'(mOperand));
    checkOutput("error", 32'(bus.error_o), 32'(mError));
    checkOutput("busy_idle", 32'(bus.busy_o), 32'd0);
    checkOutput("wr_count", wrLog.size(), expWr.size());
    for (int i = 0; i < wrLog.size() && i < expWr.size(); i++) begin
      checkOutput("wr_addr", 32'(wrLog[i].addr), 32'(expWr[i].addr));
      checkOutput("wr_mux", 32'(wrLog[i].mux), 32'(expWr[i].mux));
      if (expWr[i].mux) begin
        checkOutput("wr_res_op", 32'(wrLog[i].op), 32'(expWr[i].op));
        checkOutput("wr_res_raddr1", 32'(wrLog[i].ra1), 32'(expWr[i].ra1));
        checkOutput("wr_res_raddr2", 32'(wrLog[i].ra2), 32'(expWr[i].ra2));
      end else begin
        checkOutput("wr_data", 32'(wrLog[i].data), 32'(expWr[i].data));
      end
    end
    checkOutput("disp_count", dispCount, expDispCount);
    if (expDispCount == 1 && dispCount == 1)
      checkOutput("disp_cycle", dispCycle, expDispCycle);
    if (mPhase == M_DONE)
      checkOutput("raddr2_done", 32'(bus.raddr2_o), 32'(ADDR_RES));
    clearLogs();
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int hold);
    @(negedge clk);
    modelKey(k, cycle + 1);
    bus.teclado_i    = k;
    bus.key_detect_i = 1'b1;
    repeat (hold) @(negedge clk);
    bus.key_detect_i = 1'b0;
    repeat (GAP) @(negedge clk);
    checkSettled();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_ni         = 1'b0;
    bus.key_detect_i = 1'b0;
    repeat (2) @(negedge clk);
    modelReset();
    reset_ni = 1'b1;
    repeat (2) @(negedge clk);
    clearLogs();
    checkOutput("rst_raddr1", 32'(bus.raddr1_o), 32'(ADDR_A));
    checkOutput("rst_raddr2", 32'(bus.raddr2_o), 32'(ADDR_B));
    checkOutput("rst_operand", 32'(bus.operand_o), 32'd0);
    checkOutput("rst_error", 32'(bus.error_o), 32'd0);
    checkOutput("rst_we", 32'(bus.we_o), 32'd0);
    checkOutput("rst_alu_op", 32'(bus.alu_op_o), 32'd0);
  endtask

  initial begin
    bus.key_detect_i = 1'b0;
    bus.teclado_i    = 4'h0;
    modelReset();
    doReset();

    // Basic add: 12 + 3, then a fresh digit and clear from DONE
    applyStimulus(4'h1, 2);
    applyStimulus(4'h2, 2);
    applyStimulus(4'hA, 2);
    applyStimulus(4'h3, 2);
    applyStimulus(4'hE, 2);
    applyStimulus(4'h9, 2);
    applyStimulus(4'hF, 2);

    // Fifth digit overflows, operator then clears the error
    doReset();
    applyStimulus(4'h1, 1);
    applyStimulus(4'h2, 1);
    applyStimulus(4'h3, 1);
    applyStimulus(4'h4, 1);
    applyStimulus(4'h5, 1);
    applyStimulus(4'hC, 1);

    // Operator with no digits, then equals with no second operand
    doReset();
    applyStimulus(4'hA, 2);
    applyStimulus(4'h7, 2);
    applyStimulus(4'hB, 2);
    applyStimulus(4'hE, 2);
    applyStimulus(4'h8, 2);
    applyStimulus(4'hE, 2);

    // Key held through EXEC: one busy error, sequence unaffected
    doReset();
    applyStimulus(4'h1, 2);
    applyStimulus(4'hA, 2);
    applyStimulus(4'h3, 2);
    @(negedge clk);
    modelKey(4'hE, cycle + 1);
    bus.teclado_i    = 4'hE;
    bus.key_detect_i = 1'b1;
    @(negedge clk);
    bus.key_detect_i = 1'b0;
    @(negedge clk);
    bus.teclado_i    = 4'h5;
    bus.key_detect_i = 1'b1;
    mError = 3'b100;
    @(posedge clk);
    #1;
    checkOutput("busy_exec", 32'(bus.busy_o), 32'd1);
    repeat (50) @(negedge clk);
    bus.key_detect_i = 1'b0;
    repeat (GAP) @(negedge clk);
    checkSettled();

    // Reset asserted in EXEC: outputs drop at once, result never written
    applyStimulus(4'h2, 2);
    applyStimulus(4'hD, 2);
    applyStimulus(4'h6, 2);
    @(negedge clk);
    bus.teclado_i    = 4'hE;
    bus.key_detect_i = 1'b1;
    @(negedge clk);
    bus.key_detect_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_ni = 1'b0;
    #1;
    checkOutput("async_we", 32'(bus.we_o), 32'd0);
    checkOutput("async_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("async_operand", 32'(bus.operand_o), 32'd0);
    checkOutput("async_alu_op", 32'(bus.alu_op_o), 32'd0);
    checkOutput("async_raddr1", 32'(bus.raddr1_o), 32'(ADDR_A));
    checkOutput("async_raddr2", 32'(bus.raddr2_o), 32'(ADDR_B));
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rst_exec_wr_count", wrLog.size(), 1);
    if (wrLog.size() > 0)
      checkOutput("rst_exec_wr_addr", 32'(wrLog[0].addr), 32'(ADDR_B));
    checkOutput("rst_exec_disp", dispCount, 0);
    clearLogs();
    modelReset();
    applyStimulus(4'h4, 2);
    applyStimulus(4'hB, 2);

    // Random key traffic
    doReset();
    for (int n = 0; n < 150; n++) begin
      int         r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 72) k = 4'(10 + $urandom_range(0, 3));
      else if (r < 92) k = 4'hE;
      else             k = 4'hF;
      applyStimulus(k, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
